// File: rtl/gray_conv.sv
// gray_conv: frame-sequential RGB to 8-bit luma converter.
// For each pixel 0..IMAGE_SIZE-1 it fetches R/G/B from an upstream frame
// buffer with a four-phase req/ack handshake. It computes
// (77*R + 150*G + 29*B) >> 8 and offers the result downstream on a second
// four-phase handshake. A one-cycle frame_done pulse closes each frame.
// Optional build macro GRAY_THRESH_EN: the converter emits a binary image,
// 255 when luma >= THRESHOLD and 0 otherwise, with identical timing.
module gray_conv #(
    parameter int IMAGE_SIZE = 16384,
    parameter int THRESHOLD  = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        fb_req,
    input  logic        fb_ack,
    input  logic [7:0]  pixel_a_in,
    input  logic [7:0]  pixel_b_in,
    input  logic [7:0]  pixel_c_in,
    output logic        out_req,
    input  logic        out_ack,
    output logic [7:0]  pixel_out,
    output logic [13:0] address,
    output logic        frame_done,
    output logic [2:0]  state_out
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_FETCH_REQ  = 3'd1;
    localparam logic [2:0] ST_FETCH_WAIT = 3'd2;
    localparam logic [2:0] ST_CALC       = 3'd3;
    localparam logic [2:0] ST_SEND_REQ   = 3'd4;
    localparam logic [2:0] ST_SEND_WAIT  = 3'd5;
    localparam logic [2:0] ST_DONE       = 3'd6;

    localparam logic [13:0] LAST_ADDR = 14'(IMAGE_SIZE - 1);

    logic [2:0]  state_q, state_d;
    logic        fb_req_q, fb_req_d;
    logic        out_req_q, out_req_d;
    logic [7:0]  pix_q, pix_d;
    logic [13:0] address_q, address_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  rgb_q [3];
    logic [7:0]  rgb_d [3];

    logic [15:0] term [3];
    logic [15:0] gray_sum;
    logic [7:0]  gray_val;
    logic [7:0]  pix_calc;

    // The threshold is an 8-bit level. An out-of-range value leaves this
    // marker block in the elaborated hierarchy, where it is easy to spot.
    if ((THRESHOLD < 0) || (THRESHOLD > 255)) begin : g_threshold_out_of_range
    end

    // Weighted channel terms: R*77, G*150, B*29. The weights sum to 256,
    // so the 16-bit total peaks at 65280 and cannot overflow.
    for (genvar gi = 0; gi < 3; gi++) begin : g_term
        localparam logic [15:0] WEIGHT = (gi == 0) ? 16'd77 :
                                         ((gi == 1) ? 16'd150 : 16'd29);
        assign term[gi] = {8'd0, rgb_q[gi]} * WEIGHT;
    end

    assign gray_sum = term[0] + term[1] + term[2];
    assign gray_val = 8'(gray_sum >> 8);

`ifdef GRAY_THRESH_EN
    assign pix_calc = (gray_val >= 8'(THRESHOLD)) ? 8'hFF : 8'h00;
`else
    assign pix_calc = gray_val;
`endif

    // Next-state, address, channel latch and result register logic
    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        pix_d     = pix_q;
        for (int i = 0; i < 3; i++) begin
            rgb_d[i] = rgb_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH_REQ;
                    address_d = 14'd0;
                end
            end
            ST_FETCH_REQ: begin
                // An acknowledge that is already high on entry counts.
                if (fb_ack) begin
                    rgb_d[0] = pixel_a_in;
                    rgb_d[1] = pixel_b_in;
                    rgb_d[2] = pixel_c_in;
                    state_d  = ST_FETCH_WAIT;
                end
            end
            ST_FETCH_WAIT: begin
                if (!fb_ack) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                pix_d   = pix_calc;
                state_d = ST_SEND_REQ;
            end
            ST_SEND_REQ: begin
                if (out_ack) begin
                    state_d = ST_SEND_WAIT;
                end
            end
            ST_SEND_WAIT: begin
                if (!out_ack) begin
                    if (address_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        address_d = address_q + 14'd1;
                        state_d   = ST_FETCH_REQ;
                    end
                end
            end
            ST_DONE: begin
                address_d = 14'd0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs, registered so that they never glitch
    always_comb begin
        // fb_req rises one cycle after FETCH_REQ is entered. This gives the
        // new address a full cycle at the frame buffer before the request.
        // It falls on the edge that takes the acknowledge.
        fb_req_d     = (state_q == ST_FETCH_REQ) && (state_d == ST_FETCH_REQ);
        out_req_d    = (state_d == ST_SEND_REQ);
        frame_done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            fb_req_q     <= 1'b0;
            out_req_q    <= 1'b0;
            pix_q        <= 8'd0;
            address_q    <= 14'd0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                rgb_q[i] <= 8'd0;
            end
        end else begin
            state_q      <= state_d;
            fb_req_q     <= fb_req_d;
            out_req_q    <= out_req_d;
            pix_q        <= pix_d;
            address_q    <= address_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < 3; i++) begin
                rgb_q[i] <= rgb_d[i];
            end
        end
    end

    assign fb_req     = fb_req_q;
    assign out_req    = out_req_q;
    assign pixel_out  = pix_q;
    assign address    = address_q;
    assign frame_done = frame_done_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_gray_conv.sv
// tb_gray_conv: scoreboard bench for gray_conv on a reduced 64-pixel frame.
// Upstream and downstream partners are modelled either as zero-delay
// (the acknowledge follows the request) or as slow. A slow upstream
// acknowledges 3 clocks after the request; a slow downstream holds its
// acknowledge for 4 clocks. The expected value is queued when a fetch
// handshake completes and checked when the matching out handshake completes.
module tb_gray_conv;

    localparam int IMG = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        fb_req, fb_ack, out_req, out_ack, frame_done;
    logic [7:0]  pa, pb, pc, pixel_out;
    logic [13:0] address;
    logic [2:0]  state_out;

    logic [23:0] rgb_mem [IMG];
    logic [7:0]  exp_dir [5];

    logic slow_mode = 1'b0;
    logic fb_ack_s  = 1'b0;
    logic out_ack_s = 1'b0;
    int   fb_cnt    = 0;
    int   out_cnt   = 0;

    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    gray_conv #(.IMAGE_SIZE(IMG), .THRESHOLD(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fb_req     (fb_req),
        .fb_ack     (fb_ack),
        .pixel_a_in (pa),
        .pixel_b_in (pb),
        .pixel_c_in (pc),
        .out_req    (out_req),
        .out_ack    (out_ack),
        .pixel_out  (pixel_out),
        .address    (address),
        .frame_done (frame_done),
        .state_out  (state_out)
    );

    assign pa = rgb_mem[address[5:0]][23:16];
    assign pb = rgb_mem[address[5:0]][15:8];
    assign pc = rgb_mem[address[5:0]][7:0];

    assign fb_ack  = slow_mode ? fb_ack_s  : fb_req;
    assign out_ack = slow_mode ? out_ack_s : out_req;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gray_model(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int s;
        s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
`ifdef GRAY_THRESH_EN
        return (s / 256 >= 128) ? 8'd255 : 8'd0;
`else
        return 8'(s / 256);
`endif
    endfunction

    // Slow partner models
    always @(posedge clk) begin
        if (!fb_req) begin
            fb_cnt   <= 0;
            fb_ack_s <= 1'b0;
        end else if (fb_cnt == 2) begin
            fb_ack_s <= 1'b1;
        end else begin
            fb_cnt <= fb_cnt + 1;
        end
        if (out_ack_s) begin
            if (out_cnt == 3) begin
                out_ack_s <= 1'b0;
                out_cnt   <= 0;
            end else begin
                out_cnt <= out_cnt + 1;
            end
        end else if (out_req) begin
            out_ack_s <= 1'b1;
            out_cnt   <= 0;
        end
    end

    // Monitor / scoreboard, sampled on the falling edge
    int          cyc = 0;
    logic [7:0]  exp_q [$];
    int          pix_idx = 0;
    int          last_hs_cyc = 0;
    int          done_cnt = 0;
    logic [7:0]  frame_pix [IMG];
    logic        prev_busy = 1'b0;
    logic [7:0]  prev_pix = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            pix_idx   = 0;
            prev_busy = 1'b0;
        end else begin
            check_eq("req_excl", 32'(fb_req & out_req), 0);
            if (out_req || out_ack) begin
                if (prev_busy) check_eq("pix_stable", pixel_out, prev_pix);
                prev_busy = 1'b1;
                prev_pix  = pixel_out;
            end else begin
                prev_busy = 1'b0;
            end
            if (state_out == 3'd1 && fb_ack) begin
                exp_q.push_back(gray_model(pa, pb, pc));
            end
            if (state_out == 3'd4 && out_ack) begin
                if (exp_q.size() == 0) check_eq("sb_underflow", 1, 0);
                else check_eq("pix", pixel_out, exp_q.pop_front());
                check_eq("addr", address, pix_idx);
                if (!slow_mode && pix_idx > 0) check_eq("period", cyc - last_hs_cyc, 6);
                last_hs_cyc = cyc;
                if (pix_idx < IMG) frame_pix[pix_idx] = pixel_out;
                pix_idx++;
            end
            if (frame_done) begin
                done_cnt++;
                check_eq("frame_len", pix_idx, IMG);
                check_eq("sb_drain", exp_q.size(), 0);
                pix_idx = 0;
            end
        end
    end

    task automatic wait_frame(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        check_eq("frame_timeout", 0, 1);
    endtask

    initial begin
        int d0;
        bit found;

        rgb_mem[0] = {8'd255, 8'd255, 8'd255};
        rgb_mem[1] = {8'd100, 8'd0,   8'd0};
        rgb_mem[2] = {8'd0,   8'd200, 8'd0};
        rgb_mem[3] = {8'd0,   8'd0,   8'd0};
        rgb_mem[4] = {8'd0,   8'd220, 8'd0};
        for (int i = 5; i < IMG; i++) rgb_mem[i] = 24'($urandom);
`ifdef GRAY_THRESH_EN
        exp_dir[0] = 8'd255; exp_dir[1] = 8'd0; exp_dir[2] = 8'd0;
        exp_dir[3] = 8'd0;   exp_dir[4] = 8'd255;
`else
        exp_dir[0] = 8'd255; exp_dir[1] = 8'd30; exp_dir[2] = 8'd117;
        exp_dir[3] = 8'd0;   exp_dir[4] = 8'd128;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_state", state_out, 0);
        check_eq("rst_fb_req", fb_req, 0);
        check_eq("rst_out_req", out_req, 0);
        check_eq("rst_pixel", pixel_out, 0);
        check_eq("rst_addr", address, 0);
        check_eq("rst_done", frame_done, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_no_start", state_out, 0);

        // Frame 1: zero-delay partners, directed pixels then random
        start = 1'b1;
        @(negedge clk);
        check_eq("f1_enter", state_out, 1);
        check_eq("f1_addr0", address, 0);
        start = 1'b0;
        wait_frame(IMG * 6 + 50);
        @(negedge clk);
        check_eq("f1_done_pulse", frame_done, 0);
        check_eq("f1_addr_back", address, 0);
        check_eq("f1_idle", state_out, 0);
        check_eq("f1_done_cnt", done_cnt, 1);
        for (int i = 0; i < 5; i++) check_eq($sformatf("dir_pix%0d", i), frame_pix[i], exp_dir[i]);

        // Frames 2 and 3: slow partners, start held high across DONE
        for (int i = 5; i < IMG; i++) rgb_mem[i] = 24'($urandom);
        slow_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_eq("f2_enter", state_out, 1);
        wait_frame(IMG * 20 + 50);
        @(negedge clk);
        check_eq("f2_idle", state_out, 0);
        check_eq("f2_done_pulse", frame_done, 0);
        check_eq("f2_addr_back", address, 0);
        @(negedge clk);
        check_eq("f3_held_start", state_out, 1);
        start = 1'b0;
        wait_frame(IMG * 20 + 50);
        @(negedge clk);
        check_eq("f3_done_cnt", done_cnt, 3);

        // Reset in SEND_REQ at address 5
        slow_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (state_out == 3'd4 && address == 14'd5) found = 1'b1;
        end
        check_eq("reach_send5", 32'(found), 1);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_state", state_out, 0);
        check_eq("arst_fb_req", fb_req, 0);
        check_eq("arst_out_req", out_req, 0);
        check_eq("arst_pixel", pixel_out, 0);
        check_eq("arst_addr", address, 0);
        check_eq("arst_done", frame_done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_idle", state_out, 0);

        // Restart, with a start pulse during FETCH_WAIT
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        check_eq("restart_enter", state_out, 1);
        check_eq("restart_addr0", address, 0);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (state_out == 3'd2) found = 1'b1;
        end
        check_eq("reach_fetch_wait", 32'(found), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_frame(IMG * 6 + 50);
        repeat (20) @(negedge clk);
        check_eq("single_done", done_cnt, d0 + 1);
        check_eq("stay_idle", state_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gray_conv.md
GRAY_CONV -- requirements
Module: gray_conv

Interface
REQ-001 Parameter: IMAGE_SIZE, 16384, pixels per frame (128x128).
REQ-002 Parameter: THRESHOLD, 128, binarisation level (used only with GRAY_THRESH_EN).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 start  input  1  level; begins one frame transfer when sampled high in IDLE.
REQ-006 fb_req  output  1  fetch request to upstream frame buffer (drives its send_req).
REQ-007 fb_ack  input  1  upstream acknowledge; RGB valid while high.
REQ-008 pixel_a_in, pixel_b_in, pixel_c_in  input  8 each  R, G, B from upstream.
REQ-009 out_req  output  1  downstream request; pixel_out valid while high.
REQ-010 out_ack  input  1  downstream acknowledge.
REQ-011 pixel_out  output  8  converted pixel.
REQ-012 address  output  14  index of current pixel, 0..IMAGE_SIZE-1.
REQ-013 frame_done  output  1  one-cycle pulse after last pixel is accepted downstream.
REQ-014 state_out  output  3  current FSM state encoding.

Function
REQ-015 FSM encodings: IDLE=0, FETCH_REQ=1, FETCH_WAIT=2, CALC=3, SEND_REQ=4, SEND_WAIT=5, DONE=6; 7 unused, SHALL go to IDLE.
REQ-016 IDLE: fb_req=0, out_req=0; start=1 -> FETCH_REQ, address=0.
REQ-017 FETCH_REQ: fb_req=1; on fb_ack=1 latch pixel_a_in/b_in/c_in, drop fb_req next cycle, -> FETCH_WAIT.
REQ-018 FETCH_WAIT: fb_req=0; on fb_ack=0 -> CALC (four-phase complete).
REQ-019 CALC: one cycle; gray = (77*R + 150*G + 29*B) >> 8, 16-bit unsigned accumulate, no overflow possible (max 65280); result registered to pixel_out; -> SEND_REQ.
REQ-020 SEND_REQ: out_req=1, pixel_out stable; on out_ack=1 -> SEND_WAIT, out_req=0.
REQ-021 SEND_WAIT: on out_ack=0: if address==IMAGE_SIZE-1 -> DONE, else address+1 -> FETCH_REQ.
REQ-022 DONE: frame_done=1 for exactly one cycle, address=0, -> IDLE.
REQ-023 pixel_out SHALL not change while out_req=1 or out_ack=1.
REQ-024 start while not IDLE SHALL be ignored; start held high in IDLE after DONE SHALL begin a new frame.
REQ-025 fb_ack already high on entry to FETCH_REQ SHALL be treated as acknowledge that cycle.
REQ-026 Minimum per-pixel latency: 6 clocks with zero-delay partners (fetch 2, calc 1, send 2, advance 1).
REQ-027 fb_req and out_req SHALL never be high simultaneously.

Reset
REQ-028 reset=0: state=IDLE, fb_req=0, out_req=0, pixel_out=0, address=0, frame_done=0, latched RGB=0, asynchronously.
REQ-029 Reset mid-frame SHALL abandon the frame; after release block waits in IDLE for start.

Configuration
REQ-030 Macro GRAY_THRESH_EN defined: CALC output = 255 if gray >= THRESHOLD else 0.
REQ-031 GRAY_THRESH_EN undefined: CALC output = gray value; THRESHOLD unused; timing identical.

Verification
REQ-032 RGB (255,255,255), no macro -> pixel_out=255; (100,0,0) -> 30; (0,200,0) -> 117; (0,0,0) -> 0.
REQ-033 GRAY_THRESH_EN, THRESHOLD=128: (0,200,0) -> 0; (0,220,0) -> 128 gray -> 255; (255,255,255) -> 255.
REQ-034 Full frame IMAGE_SIZE=16384, random RGB, zero-delay partners -> 16384 out handshakes, outputs match model, frame_done pulse once, address back to 0, 6 clocks/pixel.
REQ-035 Slow partners (fb_ack delay 3 clocks, out_ack hold 4 clocks) -> no lost/duplicated pixel, pixel_out stable across out handshake, fb_req/out_req never both high.
REQ-036 reset=0 asserted in SEND_REQ at address 5 -> all outputs 0 same cycle; after release and start, frame restarts at address 0.
REQ-037 start pulsed during FETCH_WAIT -> ignored; single frame_done for the frame.
